lock_ctrl: RTL

//  Main FSM of the digital lock: takes debounced keypad pulses, checks the

---
 rtl/lock_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/lock_ctrl.sv
// Digital lock main controller: code entry, failure counting,
// auto-relock countdown, password change and alarm hold-off.
module lock_ctrl #(
    parameter int                      PWD_LEN     = 4,
    parameter logic [PWD_LEN*4-1:0]    DEFAULT_PWD = 16'h1234,
    parameter int                      TICK_DIV    = 50_000_000,
    parameter int                      ALARM_SEC   = 10
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       key_enter,
    input  logic       key_clear,
    input  logic       key_set,
    output logic [1:0] st_lock,
    output logic [2:0] st_cd,
    output logic       st_set,
    output logic [1:0] st_err,
    output logic       unlock
);

    localparam int BW  = PWD_LEN * 4;
    localparam int CW  = $clog2(PWD_LEN + 1);
    localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ASW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

    typedef enum logic [2:0] {
        S_LOCK,
        S_INPUT,
        S_UNLOCK,
        S_SET,
        S_ALARM
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  buf_q, buf_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]  pwd_q, pwd_d;
    logic [1:0]     err_q, err_d;
    logic [2:0]     cd_q, cd_d;
    logic [PSW-1:0] presc_q, presc_d;
    logic [ASW-1:0] asec_q, asec_d;
    logic [1:0]     st_lock_q, st_lock_d;
    logic           st_set_q, st_set_d;
    logic           unlock_q, unlock_d;

    logic           tick;
    logic           full;
    logic           digit_ok;
    logic           act_clear;
    logic           act_enter;
    logic           act_digit;
    logic           act_set;
    logic [BW-1:0]  buf_shift;

    assign tick      = (presc_q == PSW'(TICK_DIV - 1));
    assign full      = (cnt_q == CW'(PWD_LEN));
    assign digit_ok  = key_valid && (key_code <= 4'd9);
    assign act_clear = key_clear;
    assign act_enter = !key_clear && key_enter;
    assign act_digit = !key_clear && !key_enter && digit_ok;
    assign act_set   = !key_clear && !key_enter && !key_valid && key_set;
    assign buf_shift = (buf_q << 4) | BW'(key_code);

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        pwd_d   = pwd_q;
        err_d   = err_q;
        cd_d    = cd_q;
        asec_d  = asec_q;
        presc_d = tick ? '0 : presc_q + PSW'(1);

        unique case (state_q)
            S_LOCK: begin
                if (act_digit) begin
                    buf_d   = BW'(key_code);
                    cnt_d   = CW'(1);
                    state_d = S_INPUT;
                end
            end
            S_INPUT: begin
                if (act_clear) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = S_LOCK;
                end else if (act_enter) begin
                    buf_d = '0;
                    cnt_d = '0;
                    if (full && (buf_q == pwd_q)) begin
                        err_d   = 2'd0;
                        state_d = S_UNLOCK;
                    end else begin
                        err_d   = err_q + 2'd1;
                        state_d = (err_q == 2'd2) ? S_ALARM : S_LOCK;
                    end
                end else if (act_digit && !full) begin
                    buf_d = buf_shift;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_UNLOCK: begin
                if (act_enter) begin
                    cd_d    = 3'd0;
                    state_d = S_LOCK;
                end else if (act_set) begin
                    cd_d    = 3'd0;
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SET;
                end else if (tick) begin
                    if (cd_q == 3'd6) begin
                        cd_d    = 3'd0;
                        state_d = S_LOCK;
                    end else begin
                        cd_d = cd_q + 3'd1;
                    end
                end
            end
            S_SET: begin
                if (act_clear) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = S_UNLOCK;
                end else if (act_enter && full) begin
                    pwd_d   = buf_q;
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = S_UNLOCK;
                end else if (act_digit && !full) begin
                    buf_d = buf_shift;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ALARM: begin
                if (tick) begin
                    if (asec_q == ASW'(ALARM_SEC - 1)) begin
                        err_d   = 2'd0;
                        state_d = S_LOCK;
                    end else begin
                        asec_d = asec_q + ASW'(1);
                    end
                end
            end
            default: begin
                state_d = S_LOCK;
            end
        endcase

        if ((state_d != state_q) &&
            ((state_d == S_UNLOCK) || (state_d == S_ALARM))) begin
            presc_d = '0;
            asec_d  = '0;
            if (state_d == S_UNLOCK) begin
                cd_d = 3'd1;
            end
        end

        st_lock_d = 2'b00;
        st_set_d  = 1'b0;
        unlock_d  = 1'b0;
        unique case (state_d)
            S_INPUT:  st_lock_d = 2'b01;
            S_ALARM:  st_lock_d = 2'b10;
            S_UNLOCK: begin
                st_lock_d = 2'b11;
                unlock_d  = 1'b1;
            end
            S_SET: begin
                st_lock_d = 2'b11;
                st_set_d  = 1'b1;
                unlock_d  = 1'b1;
            end
            default: st_lock_d = 2'b00;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_LOCK;
            buf_q     <= '0;
            cnt_q     <= '0;
            pwd_q     <= DEFAULT_PWD;
            err_q     <= 2'd0;
            cd_q      <= 3'd0;
            presc_q   <= '0;
            asec_q    <= '0;
            st_lock_q <= 2'b00;
            st_set_q  <= 1'b0;
            unlock_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            pwd_q     <= pwd_d;
            err_q     <= err_d;
            cd_q      <= cd_d;
            presc_q   <= presc_d;
            asec_q    <= asec_d;
            st_lock_q <= st_lock_d;
            st_set_q  <= st_set_d;
            unlock_q  <= unlock_d;
        end
    end

    assign st_lock = st_lock_q;
    assign st_cd   = cd_q;
    assign st_set  = st_set_q;
    assign st_err  = err_q;
    assign unlock  = unlock_q;

endmodule
